// File: rtl/idelay_scan.sv
// IDELAYE2 tap scanner: sweeps all 32 taps, records which ones see the training
// pattern cleanly, then loads the centre of the longest passing window.
module idelay_scan #(
   parameter int SETTLE_CYCLES = 16,
   parameter int SAMPLE_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        match,
   input  logic        man_ld,
   input  logic [4:0]  man_tap,
   output logic [4:0]  cntvaluein,
   output logic        ld,
   output logic        busy,
   output logic        done,
   output logic        fail,
   output logic [31:0] good_map,
   output logic [4:0]  best_tap,
   output logic [5:0]  best_len
);

   typedef enum logic [2:0] {
      IDLE, LOAD, SETTLE, SAMPLE, NEXT, PICK, APPLY, DONE
   } state_t;

   state_t      state, nstate;
   logic [15:0] cnt;
   logic [4:0]  tap;
   logic        pass;
   logic [4:0]  cur_start, run_start, fin_start, pick_tap;
   logic [5:0]  cur_len, run_len, fin_len;
   logic        settle_end, sample_end;
   logic        start_go, man_go;
   logic        ld_d, done_d, busy_d;
   logic [4:0]  cv_d;

   assign settle_end = (cnt == 16'(SETTLE_CYCLES - 1));
   assign sample_end = (cnt == 16'(SAMPLE_CYCLES - 1));
   // Requests are held off while ld is high so two loads never abut.
   assign start_go   = (state == IDLE) && start && !ld;
   assign man_go     = (state == IDLE) && !start && man_ld && !ld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:    if (start_go) nstate = LOAD;
         LOAD:    nstate = SETTLE;
         SETTLE:  if (settle_end) nstate = SAMPLE;
         SAMPLE:  if (sample_end) nstate = NEXT;
         NEXT:    nstate = (tap == 5'd31) ? PICK : LOAD;
         PICK:    nstate = APPLY;
         APPLY:   nstate = DONE;
         DONE:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // A run still open at tap 31 competes here, without wrapping to tap 0.
   always_comb begin
      fin_len   = run_len;
      fin_start = run_start;
      if (cur_len > run_len) begin
         fin_len   = cur_len;
         fin_start = cur_start;
      end
      pick_tap = 5'd0;
      if (fin_len != 6'd0)
         pick_tap = fin_start + 5'((fin_len - 6'd1) >> 1);
   end

   always_comb begin
      ld_d   = 1'b0;
      cv_d   = cntvaluein;
      done_d = (nstate == DONE);
      busy_d = (nstate != IDLE) && (nstate != DONE);
      if (nstate == LOAD) begin
         ld_d = 1'b1;
         cv_d = (state == IDLE) ? 5'd0 : tap + 5'd1;
      end else if (nstate == APPLY) begin
         ld_d = 1'b1;
         cv_d = pick_tap;
      end else if (man_go) begin
         ld_d = 1'b1;
         cv_d = man_tap;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         tap        <= '0;
         pass       <= 1'b0;
         cur_start  <= '0;
         cur_len    <= '0;
         run_start  <= '0;
         run_len    <= '0;
         ld         <= 1'b0;
         cntvaluein <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fail       <= 1'b0;
         good_map   <= '0;
         best_tap   <= '0;
         best_len   <= '0;
      end else begin
         ld         <= ld_d;
         cntvaluein <= cv_d;
         busy       <= busy_d;
         done       <= done_d;
         if ((state == SETTLE && !settle_end) ||
             (state == SAMPLE && !sample_end))
            cnt <= cnt + 16'd1;
         else
            cnt <= '0;
         if (start_go) begin
            tap       <= '0;
            good_map  <= '0;
            fail      <= 1'b0;
            cur_start <= '0;
            cur_len   <= '0;
            run_start <= '0;
            run_len   <= '0;
         end
         if (man_go)
            best_tap <= man_tap;
         if (state == LOAD)
            pass <= 1'b1;
         if (state == SAMPLE)
            pass <= pass & match;
         if (state == NEXT) begin
            good_map[tap] <= pass;
            if (pass) begin
               if (cur_len == 6'd0) cur_start <= tap;
               cur_len <= cur_len + 6'd1;
            end else begin
               if (cur_len > run_len) begin
                  run_len   <= cur_len;
                  run_start <= cur_start;
               end
               cur_len <= '0;
            end
            if (tap != 5'd31) tap <= tap + 5'd1;
         end
         if (state == PICK) begin
            best_len <= fin_len;
            best_tap <= pick_tap;
            if (fin_len == 6'd0) fail <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_idelay_scan.sv
// Bench for idelay_scan: a simple IDELAY/link model feeds match, and every ld
// strobe is checked against a queue of expected tap loads.
module tb_idelay_scan;

   localparam int S = 2;
   localparam int P = 4;
   // Clock edges from the edge that accepts start to the edge that raises done.
   localparam int SCAN_EDGES = 1 + 32 * (2 + S + P) + 3 - 1;

   logic        clk = 1'b0;
   logic        rst, start, man_ld, match;
   logic [4:0]  man_tap;
   logic [4:0]  cntvaluein;
   logic        ld, busy, done, fail;
   logic [31:0] good_map;
   logic [4:0]  best_tap;
   logic [5:0]  best_len;

   int          errors = 0;
   int          checks = 0;
   logic [4:0]  exp_q[$];
   logic [31:0] pattern = '0;
   bit          glitch = 1'b0;
   logic [4:0]  dly_tap = '0;
   int          since = 0;
   logic        prev_ld = 1'b0;

   idelay_scan #(.SETTLE_CYCLES(S), .SAMPLE_CYCLES(P)) dut (
      .clk(clk), .rst(rst), .start(start), .match(match),
      .man_ld(man_ld), .man_tap(man_tap), .cntvaluein(cntvaluein),
      .ld(ld), .busy(busy), .done(done), .fail(fail),
      .good_map(good_map), .best_tap(best_tap), .best_len(best_len)
   );

   always #5 clk = ~clk;

   // Delay line model: tap latched on LD; one-cycle glitch in the second
   // SAMPLE cycle of tap 31 when enabled.
   always @(posedge clk) begin
      if (ld) begin
         dly_tap <= cntvaluein;
         since   <= 0;
      end else begin
         since <= since + 1;
      end
   end

   assign match = pattern[dly_tap] &&
                  !(glitch && dly_tap == 5'd31 && since == S + 1);

   // Scoreboard for load strobes.
   always @(negedge clk) begin
      if (ld) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL ld_unexpected: got cntvaluein=%0d, want no ld", cntvaluein);
         end else begin
            logic [4:0] e;
            e = exp_q.pop_front();
            if (cntvaluein !== e) begin
               errors++;
               $display("FAIL ld_value: got %0d, want %0d", cntvaluein, e);
            end
         end
         checks++;
         if (prev_ld) begin
            errors++;
            $display("FAIL ld_width: got ld high 2 cycles, want 1");
         end
      end
      prev_ld = ld;
   end

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; man_ld = 1'b0; man_tap = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ld, busy, done, fail} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b, want 0000", {ld, busy, done, fail});
      end
      checks++;
      if ({cntvaluein, best_tap, best_len, good_map} !== '0) begin
         errors++;
         $display("FAIL reset_values: got cv=%0d bt=%0d bl=%0d map=%h, want 0",
                  cntvaluein, best_tap, best_len, good_map);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic run_scan(input string name, input logic [31:0] pat,
                           input bit gl, input bit with_man, input bit poke,
                           input logic [31:0] exp_map, input logic [5:0] exp_len,
                           input logic [4:0] exp_tap, input logic exp_fail);
      int n;
      pattern = pat;
      glitch  = gl;
      for (int i = 0; i < 32; i++) exp_q.push_back(5'(i));
      exp_q.push_back(exp_tap);
      @(negedge clk);
      start = 1'b1; man_ld = with_man; man_tap = 5'd27;
      @(negedge clk);
      start = 1'b0; man_ld = 1'b0;
      n = 1;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s_busy: got %b, want 1", name, busy);
      end
      while (!done && n < SCAN_EDGES + 20) begin
         start  = poke && (n == 100);
         man_ld = poke && (n == 100);
         @(negedge clk);
         n++;
      end
      start = 1'b0; man_ld = 1'b0;
      checks++;
      if (n != SCAN_EDGES) begin
         errors++;
         $display("FAIL %s_latency: got %0d edges, want %0d", name, n, SCAN_EDGES);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL %s_done: got busy=%b done=%b, want 0 1", name, busy, done);
      end
      checks++;
      if (good_map !== exp_map) begin
         errors++;
         $display("FAIL %s_map: got %h, want %h", name, good_map, exp_map);
      end
      checks++;
      if (best_len !== exp_len || best_tap !== exp_tap || fail !== exp_fail) begin
         errors++;
         $display("FAIL %s_pick: got len=%0d tap=%0d fail=%b, want %0d %0d %b",
                  name, best_len, best_tap, fail, exp_len, exp_tap, exp_fail);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_loads: got %0d loads missing, want 0", name, exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL %s_done_pulse: got %b, want 0", name, done);
      end
   endtask

   task automatic test_manual_after_fail();
      exp_q.push_back(5'd22);
      man_ld = 1'b1; man_tap = 5'd22;
      @(negedge clk);
      man_ld = 1'b0;
      checks++;
      if (ld !== 1'b1 || best_tap !== 5'd22) begin
         errors++;
         $display("FAIL man_load: got ld=%b tap=%0d, want 1 22", ld, best_tap);
      end
      checks++;
      if (fail !== 1'b1 || good_map !== 32'h0 || best_len !== 6'd0) begin
         errors++;
         $display("FAIL man_keep: got fail=%b map=%h len=%0d, want 1 0 0",
                  fail, good_map, best_len);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_scan();
      int k;
      pattern = 32'hFFFF_FFFF;
      glitch  = 1'b0;
      for (int i = 0; i < 8; i++) exp_q.push_back(5'(i));
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!(dly_tap == 5'd7 && since == S + 1) && k < 200) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= 200) begin
         errors++;
         $display("FAIL rmid_reach: got timeout, want tap 7 sample");
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({ld, busy, done, fail, cntvaluein, best_tap, best_len, good_map} !== '0) begin
         errors++;
         $display("FAIL rmid_zero: got ld=%b busy=%b map=%h cv=%0d, want all 0",
                  ld, busy, good_map, cntvaluein);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rmid_loads: got %0d missing, want 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.push_back(5'd9);
      man_ld = 1'b1; man_tap = 5'd9;
      @(negedge clk);
      man_ld = 1'b0;
      checks++;
      if (ld !== 1'b1 || cntvaluein !== 5'd9 || best_tap !== 5'd9) begin
         errors++;
         $display("FAIL rmid_man: got ld=%b cv=%0d tap=%0d, want 1 9 9",
                  ld, cntvaluein, best_tap);
      end
      @(negedge clk);
      checks++;
      if (ld !== 1'b0 || cntvaluein !== 5'd9) begin
         errors++;
         $display("FAIL rmid_hold: got ld=%b cv=%0d, want 0 9", ld, cntvaluein);
      end
   endtask

   initial begin
      test_reset();
      run_scan("all_pass", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0,
               32'hFFFF_FFFF, 6'd32, 5'd15, 1'b0);
      run_scan("window", 32'h001F_FC00, 1'b0, 1'b0, 1'b0,
               32'h001F_FC00, 6'd11, 5'd15, 1'b0);
      run_scan("tie", 32'h00F0_0078, 1'b0, 1'b0, 1'b0,
               32'h00F0_0078, 6'd4, 5'd4, 1'b0);
      run_scan("glitch", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1,
               32'h7FFF_FFFF, 6'd31, 5'd15, 1'b0);
      run_scan("none", 32'h0, 1'b0, 1'b0, 1'b0,
               32'h0, 6'd0, 5'd0, 1'b1);
      test_manual_after_fail();
      test_reset_mid_scan();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_queue: got %0d pending, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
